tile_rom_arbiter: RTL and testbench

- Round-robin arbiter that shares one synchronous tile/sprite ROM read port among N pixel-fetch requesters (brick, question, cloud, hill layers).
- Issues at most one ROM read per clock and pipelines the requester ID alongside the ROM latency.
- Returns each read as a tagged, registered response.
- Sits between the per-layer draw logic and a single *_rom instance whose data_Out is registered one cycle after read_address is sampled.

---
 rtl/tile_rom_arbiter.sv | 111 +++++++++++
 tb/tb_tile_rom_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_rom_arbiter.sv
// Round-robin arbiter that shares one synchronous tile/sprite ROM read port
// among N pixel-fetch requesters. At most one read is issued per clock. The
// requester ID travels alongside the ROM latency, and each read comes back as
// a tagged, registered response.
module tile_rom_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned ROM_LAT = 1,
    parameter int unsigned IDW     = $clog2(N)
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  hold,
    input  logic [N-1:0]          req,
    input  logic [N*ADDR_W-1:0]   req_addr,
    output logic [N-1:0]          gnt,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  busy
);

    logic [IDW-1:0] rr_ptr;
    logic           grant_any;
    logic [IDW-1:0] grant_id;
    logic           pipe_valid [ROM_LAT];
    logic [IDW-1:0] pipe_id    [ROM_LAT];

    // Pick the first requester at or after rr_ptr, wrapping modulo N (not 2^IDW).
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        if (Reset_n && !hold) begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = 32'(rr_ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!grant_any && req[idx[IDW-1:0]]) begin
                    grant_any = 1'b1;
                    grant_id  = idx[IDW-1:0];
                end
            end
        end
    end

    // One-hot grant and the granted requester's address for the ROM port.
    always_comb begin
        gnt      = '0;
        rom_addr = '0;
        if (grant_any) begin
            gnt[grant_id] = 1'b1;
            rom_addr      = req_addr[32'(grant_id) * ADDR_W +: ADDR_W];
        end
    end

    // Round-robin pointer moves past the winner; it holds when nothing is granted.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // {valid, id} shift register that tracks the ROM read latency.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned s = 0; s < ROM_LAT; s++) begin
                pipe_valid[s] <= 1'b0;
                pipe_id[s]    <= '0;
            end
        end else begin
            pipe_valid[0] <= grant_any;
            pipe_id[0]    <= grant_id;
            for (int unsigned s = 1; s < ROM_LAT; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_id[s]    <= pipe_id[s-1];
            end
        end
    end

    // Capture the ROM word when the last stage is valid; id/data otherwise hold.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= pipe_valid[ROM_LAT-1];
            if (pipe_valid[ROM_LAT-1]) begin
                rsp_id   <= pipe_id[ROM_LAT-1];
                rsp_data <= rom_data;
            end
        end
    end

    // Busy covers the current grant and every read still inside the pipeline.
    always_comb begin
        busy = grant_any;
        for (int unsigned s = 0; s < ROM_LAT; s++) begin
            busy = busy | pipe_valid[s];
        end
    end

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Bench for tile_rom_arbiter. It drives two instances: a default one (N=4,
// ROM_LAT=1) and a small one (N=3, ROM_LAT=3). A per-cycle reference model
// tracks the round-robin pointer and a schedule of due responses.
module tb_tile_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Instance a: N=4, ROM_LAT=1
    logic        hold_a;
    logic [3:0]  req_a;
    logic [11:0] addr_a [4];
    logic [3:0]  gnt_a;
    logic [11:0] ra_a;
    logic [23:0] rom_a_q;
    logic        rv_a;
    logic [1:0]  rid_a;
    logic [23:0] rdat_a;
    logic        busy_a;

    // Instance b: N=3, ROM_LAT=3
    logic        hold_b;
    logic [2:0]  req_b;
    logic [11:0] addr_b [3];
    logic [2:0]  gnt_b;
    logic [11:0] ra_b;
    logic [23:0] rom_b_q [3];
    logic        rv_b;
    logic [1:0]  rid_b;
    logic [23:0] rdat_b;
    logic        busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tile_rom_arbiter #(.N(4), .ADDR_W(12), .DATA_W(24), .ROM_LAT(1)) dut_a (
        .Clk(clk), .Reset_n(rst_n), .hold(hold_a), .req(req_a),
        .req_addr({addr_a[3], addr_a[2], addr_a[1], addr_a[0]}),
        .gnt(gnt_a), .rom_addr(ra_a), .rom_data(rom_a_q),
        .rsp_valid(rv_a), .rsp_id(rid_a), .rsp_data(rdat_a), .busy(busy_a)
    );

    tile_rom_arbiter #(.N(3), .ADDR_W(12), .DATA_W(24), .ROM_LAT(3)) dut_b (
        .Clk(clk), .Reset_n(rst_n), .hold(hold_b), .req(req_b),
        .req_addr({addr_b[2], addr_b[1], addr_b[0]}),
        .gnt(gnt_b), .rom_addr(ra_b), .rom_data(rom_b_q[2]),
        .rsp_valid(rv_b), .rsp_id(rid_b), .rsp_data(rdat_b), .busy(busy_b)
    );

    // ROM contents: a fixed scramble of the address.
    function automatic logic [23:0] rom_f(input logic [11:0] a);
        return {a ^ 12'hA5C, a[5:0], a[11:6]};
    endfunction

    // Synchronous ROMs with 1 and 3 cycles of read latency.
    always @(posedge clk) begin
        rom_a_q    <= rom_f(ra_a);
        rom_b_q[0] <= rom_f(ra_b);
        rom_b_q[1] <= rom_b_q[0];
        rom_b_q[2] <= rom_b_q[1];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;
    int          m_ptr   [2];
    int          m_gid   [2];
    logic [11:0] m_gaddr [2];
    logic [3:0]  m_last_gnt [2];
    bit          sv  [2][8];
    int          sid [2][8];
    logic [23:0] sd  [2][8];
    int          outst   [2];
    int          last_id [2];
    logic [23:0] last_d  [2];

    function automatic logic [11:0] get_addr(input int inst, input int i);
        return (inst == 0) ? addr_a[i] : addr_b[i];
    endfunction

    task automatic model_eval(input int inst);
        int n; int slot; int idx;
        logic [3:0] r; logic h;
        logic [3:0] eg; logic [11:0] ea; logic ev; logic eb;
        logic [3:0] ag; logic [11:0] aa; logic av; logic [1:0] aid; logic [23:0] ad; logic ab;
        string p;
        n  = (inst == 0) ? 4 : 3;
        p  = (inst == 0) ? "a" : "b";
        r  = (inst == 0) ? req_a : {1'b0, req_b};
        h  = (inst == 0) ? hold_a : hold_b;
        ag = (inst == 0) ? gnt_a : {1'b0, gnt_b};
        aa = (inst == 0) ? ra_a : ra_b;
        av = (inst == 0) ? rv_a : rv_b;
        aid = (inst == 0) ? rid_a : rid_b;
        ad = (inst == 0) ? rdat_a : rdat_b;
        ab = (inst == 0) ? busy_a : busy_b;
        m_gid[inst] = -1;
        eg = '0;
        ea = '0;
        ev = 1'b0;
        if (!rst_n) begin
            m_ptr[inst]   = 0;
            outst[inst]   = 0;
            last_id[inst] = 0;
            last_d[inst]  = '0;
            for (int s = 0; s < 8; s++) sv[inst][s] = 1'b0;
        end else begin
            if (!h) begin
                for (int k = 0; k < n; k++) begin
                    idx = (m_ptr[inst] + k) % n;
                    if (m_gid[inst] < 0 && r[idx]) m_gid[inst] = idx;
                end
            end
            if (m_gid[inst] >= 0) begin
                eg = 4'(1 << m_gid[inst]);
                ea = get_addr(inst, m_gid[inst]);
            end
            slot = cyc % 8;
            ev = sv[inst][slot];
            if (ev) begin
                sv[inst][slot] = 1'b0;
                outst[inst]--;
                last_id[inst] = sid[inst][slot];
                last_d[inst]  = sd[inst][slot];
            end
        end
        m_gaddr[inst] = ea;
        eb = (m_gid[inst] >= 0) || (outst[inst] > 0);
        chk({p, ".gnt"},       32'(ag),  32'(eg));
        chk({p, ".rom_addr"},  32'(aa),  32'(ea));
        chk({p, ".rsp_valid"}, 32'(av),  32'(ev));
        chk({p, ".rsp_id"},    32'(aid), 32'(last_id[inst]));
        chk({p, ".rsp_data"},  32'(ad),  32'(last_d[inst]));
        chk({p, ".busy"},      32'(ab),  32'(eb));
    endtask

    task automatic model_step(input int inst);
        int n; int lat; int slot;
        n   = (inst == 0) ? 4 : 3;
        lat = (inst == 0) ? 1 : 3;
        m_last_gnt[inst] = '0;
        if (rst_n && m_gid[inst] >= 0) begin
            slot = (cyc + lat + 1) % 8;
            sv[inst][slot]  = 1'b1;
            sid[inst][slot] = m_gid[inst];
            sd[inst][slot]  = rom_f(m_gaddr[inst]);
            outst[inst]++;
            m_ptr[inst] = (m_gid[inst] + 1) % n;
            m_last_gnt[inst] = 4'(1 << m_gid[inst]);
        end
    endtask

    // Compare process: check outputs mid-cycle, advance the model at the edge.
    initial begin
        forever begin
            @(negedge clk);
            model_eval(0);
            model_eval(1);
            @(posedge clk);
            model_step(0);
            model_step(1);
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Instance a: round-robin, wrap fairness, hold, reset mid-flight.
    task automatic a_seq();
        logic [3:0] rr_exp [7];
        int id;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("rr.gnt", 32'(gnt_a), 32'(rr_exp[k]));
            if (k >= 2) begin
                id = (k - 2) % 4;
                chk("rr.rsp_valid", 32'(rv_a), 32'd1);
                chk("rr.rsp_id", 32'(rid_a), 32'(id));
                chk("rr.rsp_data", 32'(rdat_a), 32'(rom_f(12'(12'h010 * (id + 1)))));
            end
            next_cycle();
        end
        req_a = 4'b1001;
        @(negedge clk); chk("wrap.gnt3", 32'(gnt_a), 32'h8);
        next_cycle();
        @(negedge clk); chk("wrap.gnt0", 32'(gnt_a), 32'h1);
        next_cycle();
        @(negedge clk); chk("wrap.gnt3b", 32'(gnt_a), 32'h8);
        next_cycle();
        req_a = 4'b0110;
        @(negedge clk); chk("hold.pre_gnt", 32'(gnt_a), 32'h2);
        next_cycle();
        hold_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold.gnt", 32'(gnt_a), 32'h0);
            if (k == 0) begin
                chk("hold.rsp3_valid", 32'(rv_a), 32'd1);
                chk("hold.rsp3_id", 32'(rid_a), 32'd3);
                chk("hold.busy0", 32'(busy_a), 32'd1);
            end
            if (k == 1) begin
                chk("hold.rsp1_valid", 32'(rv_a), 32'd1);
                chk("hold.rsp1_id", 32'(rid_a), 32'd1);
                chk("hold.rsp1_data", 32'(rdat_a), 32'(rom_f(12'h020)));
                chk("hold.busy1", 32'(busy_a), 32'd0);
            end
            if (k >= 2) chk("hold.idle_valid", 32'(rv_a), 32'd0);
            next_cycle();
        end
        hold_a = 1'b0;
        @(negedge clk); chk("hold.release_gnt", 32'(gnt_a), 32'h4);
        next_cycle();
        @(negedge clk); chk("rst.pre_gnt", 32'(gnt_a), 32'h2);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst.gnt", 32'(gnt_a), 32'h0);
        chk("rst.rom_addr", 32'(ra_a), 32'h0);
        chk("rst.rsp_valid", 32'(rv_a), 32'd0);
        chk("rst.busy", 32'(busy_a), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        req_a = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst.after_valid", 32'(rv_a), 32'd0);
            chk("rst.after_busy", 32'(busy_a), 32'd0);
            next_cycle();
        end
    endtask

    // Instance b: single requester streaming 8 addresses at ROM_LAT=3.
    task automatic b_seq();
        for (int k = 0; k < 13; k++) begin
            if (k < 8) begin
                req_b     = 3'b100;
                addr_b[2] = 12'(12'h100 + k * 12'h011);
            end else begin
                req_b = 3'b000;
            end
            @(negedge clk);
            if (k < 8) begin
                chk("stream.gnt", 32'(gnt_b), 32'h4);
                chk("stream.rom_addr", 32'(ra_b), 32'(12'h100 + k * 12'h011));
            end
            if (k >= 4 && k < 12) begin
                chk("stream.rsp_valid", 32'(rv_b), 32'd1);
                chk("stream.rsp_id", 32'(rid_b), 32'd2);
                chk("stream.rsp_data", 32'(rdat_b), 32'(rom_f(12'(12'h100 + (k - 4) * 12'h011))));
            end
            if (k == 12) begin
                chk("stream.drained_valid", 32'(rv_b), 32'd0);
                chk("stream.drained_busy", 32'(busy_b), 32'd0);
            end
            next_cycle();
        end
    endtask

    initial begin
        int rst_cnt;
        rst_cnt = 0;
        hold_a = 1'b0;
        hold_b = 1'b0;
        req_a  = 4'b1111;
        req_b  = 3'b000;
        addr_a = '{12'h010, 12'h020, 12'h030, 12'h040};
        addr_b = '{12'h000, 12'h000, 12'h000};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("reset.gnt", 32'(gnt_a), 32'h0);
            chk("reset.rom_addr", 32'(ra_a), 32'h0);
            chk("reset.rsp_valid", 32'(rv_a), 32'd0);
            chk("reset.busy", 32'(busy_a), 32'd0);
        end
        next_cycle();
        rst_n = 1'b1;
        fork
            a_seq();
            b_seq();
        join

        // Randomized traffic: requests held until granted, random hold and resets.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if (rst_n && $urandom_range(0, 399) == 0) begin
                rst_n   = 1'b0;
                rst_cnt = int'($urandom_range(1, 2));
            end else if (!rst_n) begin
                rst_cnt--;
                if (rst_cnt <= 0) rst_n = 1'b1;
            end
            hold_a = ($urandom_range(0, 7) == 0);
            hold_b = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 4; i++) begin
                if (req_a[i]) begin
                    if (m_last_gnt[0][i]) begin
                        if ($urandom_range(0, 1) == 0) req_a[i] = 1'b0;
                        else addr_a[i] = 12'($urandom);
                    end else if ($urandom_range(0, 63) == 0) begin
                        req_a[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    req_a[i]  = 1'b1;
                    addr_a[i] = 12'($urandom);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (req_b[i]) begin
                    if (m_last_gnt[1][i]) begin
                        if ($urandom_range(0, 1) == 0) req_b[i] = 1'b0;
                        else addr_b[i] = 12'($urandom);
                    end
                end else if ($urandom_range(0, 1) == 0) begin
                    req_b[i]  = 1'b1;
                    addr_b[i] = 12'($urandom);
                end
            end
        end
        req_a  = 4'b0000;
        req_b  = 3'b000;
        hold_a = 1'b0;
        hold_b = 1'b0;
        rst_n  = 1'b1;
        repeat (8) next_cycle();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
